// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - time-set request/response handshake bundle
interface bcd_time_counter_if;
   logic        set_valid;
   logic [23:0] set_time;
   logic        set_ready;
   logic        set_done;
   logic        set_err;

   modport master (
      output set_valid,
      output set_time,
      input  set_ready,
      input  set_done,
      input  set_err
   );

   modport slave (
      input  set_valid,
      input  set_time,
      output set_ready,
      output set_done,
      output set_err
   );
endinterface

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - cascaded-BCD time-of-day counter with 12/24h display and validated set
module bcd_time_counter #(
   parameter int          CLK_FREQ_HZ = 100000000,
   parameter logic [23:0] RESET_TIME  = 24'h043440
) (
   input  logic                      sys_clk,
   input  logic                      rst,
   input  logic                      run_en,
   input  logic                      mode_12h,
   bcd_time_counter_if.slave         set_bus,
   output logic [3:0]                hours_tens,
   output logic [3:0]                hours_ones,
   output logic [3:0]                minutes_tens,
   output logic [3:0]                minutes_ones,
   output logic [3:0]                seconds_tens,
   output logic [3:0]                seconds_ones,
   output logic                      pm,
   output logic                      sec_tick,
   output logic                      day_tick
);

   localparam int              PRE_W   = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);

   typedef enum logic {
      IDLE,
      CHECK
   } set_state_t;

   set_state_t       state;
   set_state_t       state_next;
   logic [PRE_W-1:0] prescaler;
   logic [23:0]      time_r;
   logic [23:0]      time_inc;
   logic [23:0]      shadow;
   logic             tick;
   logic             wrap_day;
   logic             shadow_legal;
   logic             set_ready_c;
   logic             set_load;
   logic             set_reject;
   logic             set_done_r;
   logic             set_err_r;
   logic [4:0]       hour_bin;
   logic [4:0]       disp_hour;
   logic [4:0]       disp_ones;
   logic [3:0]       disp_tens;
   logic             disp_pm;

   assign tick = run_en && (prescaler == PRE_MAX);

   assign set_bus.set_ready = set_ready_c;
   assign set_bus.set_done  = set_done_r;
   assign set_bus.set_err   = set_err_r;

   // Hours may only be 00-23; minute and second tens stop at 5.
   assign shadow_legal = (shadow[23:20] <= 4'd2) &&
                         (shadow[19:16] <= 4'd9) &&
                         !((shadow[23:20] == 4'd2) && (shadow[19:16] > 4'd3)) &&
                         (shadow[15:12] <= 4'd5) &&
                         (shadow[11:8]  <= 4'd9) &&
                         (shadow[7:4]   <= 4'd5) &&
                         (shadow[3:0]   <= 4'd9);

   always_comb begin
      time_inc = time_r;
      wrap_day = 1'b0;
      if (time_r[3:0] != 4'd9) begin
         time_inc[3:0] = time_r[3:0] + 4'd1;
      end else begin
         time_inc[3:0] = 4'd0;
         if (time_r[7:4] != 4'd5) begin
            time_inc[7:4] = time_r[7:4] + 4'd1;
         end else begin
            time_inc[7:4] = 4'd0;
            if (time_r[11:8] != 4'd9) begin
               time_inc[11:8] = time_r[11:8] + 4'd1;
            end else begin
               time_inc[11:8] = 4'd0;
               if (time_r[15:12] != 4'd5) begin
                  time_inc[15:12] = time_r[15:12] + 4'd1;
               end else begin
                  time_inc[15:12] = 4'd0;
                  if ((time_r[23:20] == 4'd2) && (time_r[19:16] == 4'd3)) begin
                     time_inc[23:16] = 8'h00;
                     wrap_day        = 1'b1;
                  end else if (time_r[19:16] == 4'd9) begin
                     time_inc[19:16] = 4'd0;
                     time_inc[23:20] = time_r[23:20] + 4'd1;
                  end else begin
                     time_inc[19:16] = time_r[19:16] + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      state_next  = state;
      set_ready_c = 1'b0;
      set_load    = 1'b0;
      set_reject  = 1'b0;
      case (state)
         IDLE: begin
            set_ready_c = 1'b1;
            if (set_bus.set_valid) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            state_next = IDLE;
            set_load   = shadow_legal;
            set_reject = !shadow_legal;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A legal set takes priority over a coincident tick and swallows its strobes.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         shadow     <= RESET_TIME;
         prescaler  <= '0;
         time_r     <= RESET_TIME;
         sec_tick   <= 1'b0;
         day_tick   <= 1'b0;
         set_done_r <= 1'b0;
         set_err_r  <= 1'b0;
      end else begin
         if ((state == IDLE) && set_bus.set_valid) begin
            shadow <= set_bus.set_time;
         end
         if (set_load) begin
            prescaler <= '0;
         end else if (run_en) begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
         end
         if (set_load) begin
            time_r <= shadow;
         end else if (tick) begin
            time_r <= time_inc;
         end
         sec_tick   <= tick && !set_load;
         day_tick   <= tick && !set_load && wrap_day;
         set_done_r <= set_load;
         set_err_r  <= set_reject;
      end
   end

   assign hour_bin = (5'(time_r[23:20]) * 5'd10) + 5'(time_r[19:16]);

   always_comb begin
      disp_hour = hour_bin;
      disp_pm   = 1'b0;
      if (mode_12h) begin
         if (hour_bin == 5'd0) begin
            disp_hour = 5'd12;
         end else if (hour_bin >= 5'd12) begin
            disp_pm = 1'b1;
            if (hour_bin > 5'd12) begin
               disp_hour = hour_bin - 5'd12;
            end
         end
      end
      if (disp_hour >= 5'd20) begin
         disp_tens = 4'd2;
         disp_ones = disp_hour - 5'd20;
      end else if (disp_hour >= 5'd10) begin
         disp_tens = 4'd1;
         disp_ones = disp_hour - 5'd10;
      end else begin
         disp_tens = 4'd0;
         disp_ones = disp_hour;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         hours_tens   <= RESET_TIME[23:20];
         hours_ones   <= RESET_TIME[19:16];
         minutes_tens <= RESET_TIME[15:12];
         minutes_ones <= RESET_TIME[11:8];
         seconds_tens <= RESET_TIME[7:4];
         seconds_ones <= RESET_TIME[3:0];
         pm           <= 1'b0;
      end else begin
         hours_tens   <= disp_tens;
         hours_ones   <= disp_ones[3:0];
         minutes_tens <= time_r[15:12];
         minutes_ones <= time_r[11:8];
         seconds_tens <= time_r[7:4];
         seconds_ones <= time_r[3:0];
         pm           <= disp_pm;
      end
   end

endmodule
